// File: rtl/note_oscillator_pkg.sv
// Shared synth constants: sample rate, default waveform widths and the top-octave
// phase-increment ROM (MIDI notes 84..95 at 31.25 kHz, 20-bit phase).
package note_oscillator_pkg;

    localparam int unsigned SAMPLE_RATE     = 31250;
    localparam int unsigned DEF_BITDEPTH    = 14;
    localparam int unsigned DEF_BITFRACTION = 6;
    localparam int unsigned NOTE_W          = 7;
    localparam int unsigned INC_W           = 16;
    localparam int unsigned ROM_W           = 17;
    localparam int unsigned SEMI_W          = 4;

    // round(f * 2^20 / 31250) for the octave starting at MIDI note 84
    function automatic logic [ROM_W-1:0] note_rom(input logic [SEMI_W-1:0] semi);
        logic [ROM_W-1:0] val;
        case (semi)
            4'd0:    val = 17'd35115;
            4'd1:    val = 17'd37203;
            4'd2:    val = 17'd39415;
            4'd3:    val = 17'd41759;
            4'd4:    val = 17'd44242;
            4'd5:    val = 17'd46873;
            4'd6:    val = 17'd49660;
            4'd7:    val = 17'd52613;
            4'd8:    val = 17'd55741;
            4'd9:    val = 17'd59056;
            4'd10:   val = 17'd62567;
            4'd11:   val = 17'd66288;
            default: val = 17'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/midi_note_to_accumulator.sv
// Maps a MIDI note to a registered 16-bit phase increment: octave/semitone split,
// top-octave ROM lookup, right shift by octave distance, saturation to 65535.
module midi_note_to_accumulator
    import note_oscillator_pkg::*;
(
    input  logic              sample_clock,
    input  logic              rst,
    input  logic [NOTE_W-1:0] midi_note,
    output logic [INC_W-1:0]  increment
);

    logic [SEMI_W-1:0] octave;
    logic [SEMI_W-1:0] semi;
    logic [ROM_W-1:0]  rom_val;
    logic [ROM_W-1:0]  raw;
    logic [INC_W-1:0]  inc_next;

    // Octaves above 7 and the 17-bit ROM tail (note 95) both clamp to full scale
    always_comb begin
        octave   = SEMI_W'(midi_note / 7'd12);
        semi     = SEMI_W'(midi_note % 7'd12);
        rom_val  = note_rom(semi);
        raw      = rom_val >> (3'd7 - octave[2:0]);
        inc_next = raw[INC_W-1:0];
        if ((octave > 4'd7) || raw[ROM_W-1]) begin
            inc_next = {INC_W{1'b1}};
        end
    end

    always_ff @(posedge sample_clock or negedge rst) begin
        if (!rst) begin
            increment <= '0;
        end else begin
            increment <= inc_next;
        end
    end

endmodule

// File: rtl/note_oscillator.sv
// Single-voice tone source: one phase accumulator driven by the note increment,
// decoded into saw, triangle, pulse and sub-octave square outputs.
module note_oscillator
    import note_oscillator_pkg::*;
#(
    parameter int unsigned BITDEPTH    = DEF_BITDEPTH,
    parameter int unsigned BITFRACTION = DEF_BITFRACTION
) (
    input  logic                sample_clock,
    input  logic                rst,
    input  logic [NOTE_W-1:0]   midi_note,
    output logic [INC_W-1:0]    increment,
    output logic [BITDEPTH-1:0] saw,
    output logic [BITDEPTH-1:0] triangle,
    output logic [BITDEPTH-1:0] pulse,
    output logic [BITDEPTH-1:0] sub
);

    localparam int unsigned ACCW = BITDEPTH + BITFRACTION;
    localparam int unsigned SUMW = ACCW + 1;

    logic [ACCW-1:0]     phase;
    logic                toggle;
    logic [SUMW-1:0]     sum;
    logic [BITDEPTH-1:0] p;
    logic                m;

    midi_note_to_accumulator u_note_map (
        .sample_clock (sample_clock),
        .rst          (rst),
        .midi_note    (midi_note),
        .increment    (increment)
    );

    // Extra top bit of the sum is the wrap event that clocks the sub-octave toggle
    assign sum = {1'b0, phase} + SUMW'(increment);

    always_ff @(posedge sample_clock or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            toggle <= 1'b0;
        end else begin
            phase  <= sum[ACCW-1:0];
            toggle <= toggle ^ sum[ACCW];
        end
    end

    assign p = phase[ACCW-1:BITFRACTION];
    assign m = p[BITDEPTH-1];

    assign saw      = p;
    assign triangle = {p[BITDEPTH-2:0], 1'b0} ^ {BITDEPTH{m}};
    assign pulse    = {BITDEPTH{m}};
    assign sub      = {BITDEPTH{toggle}};

endmodule

// File: tb/tb_note_oscillator.sv
// Self-checking bench for note_oscillator: directed spot checks plus randomized
// note changes and async resets against an arithmetic reference model.
module tb_note_oscillator;

    logic        clk;
    logic        rst;
    logic [6:0]  note;
    logic [15:0] increment;
    logic [13:0] saw;
    logic [13:0] triangle;
    logic [13:0] pulse;
    logic [13:0] sub;

    int n_tests;
    int n_fail;

    // reference model state
    int m_inc;
    int m_phase;
    bit m_tog;
    int m_wraps;

    int rom_tbl [12] = '{35115, 37203, 39415, 41759, 44242, 46873,
                         49660, 52613, 55741, 59056, 62567, 66288};

    note_oscillator dut (
        .sample_clock (clk),
        .rst          (rst),
        .midi_note    (note),
        .increment    (increment),
        .saw          (saw),
        .triangle     (triangle),
        .pulse        (pulse),
        .sub          (sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_inc(input int n);
        int o;
        int raw;
        o = n / 12;
        if (o > 7) return 65535;
        raw = rom_tbl[n % 12] / (1 << (7 - o));
        return (raw > 65535) ? 65535 : raw;
    endfunction

    function automatic int ref_saw();
        return m_phase / 64;
    endfunction

    function automatic int ref_tri();
        int s;
        s = ref_saw();
        return (s >= 8192) ? (32767 - 2 * s) : (2 * s);
    endfunction

    task automatic model_clear();
        m_inc   = 0;
        m_phase = 0;
        m_tog   = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".inc"},   int'(increment), m_inc);
        check({tag, ".phase"}, int'(dut.phase), m_phase);
        check({tag, ".saw"},   int'(saw),       ref_saw());
        check({tag, ".tri"},   int'(triangle),  ref_tri());
        check({tag, ".pulse"}, int'(pulse),     (ref_saw() >= 8192) ? 16383 : 0);
        check({tag, ".sub"},   int'(sub),       m_tog ? 16383 : 0);
    endtask

    // one sample edge: model advances with the increment held before the edge
    task automatic step(input string tag);
        int np;
        @(posedge clk);
        if (rst) begin
            np = m_phase + m_inc;
            if (np >= (1 << 20)) begin
                np -= (1 << 20);
                m_tog = !m_tog;
                m_wraps++;
            end
            m_phase = np;
            m_inc   = ref_inc(int'(note));
        end
        #1;
        compare_all(tag);
    endtask

    // assert reset between edges, confirm immediate clear, release before next edge
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        compare_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int spot_notes [7] = '{60, 69, 84, 94, 95, 127, 0};
    int spot_exp   [7] = '{8778, 14764, 35115, 62567, 65535, 65535, 274};

    initial begin
        int saw_drops;
        int sub_flips;
        int prev_saw;
        int prev_sub;
        int prev_phase;
        n_tests = 0;
        n_fail  = 0;
        m_wraps = 0;
        model_clear();

        // reset held across edges
        rst  = 1'b0;
        note = 7'd60;
        repeat (3) step("rst");
        @(negedge clk);
        rst = 1'b1;
        step("release");
        check("release.inc8778", int'(increment), 8778);
        check("release.phase0", int'(dut.phase), 0);

        // mapping spot checks against hand-derived constants
        for (int i = 0; i < 7; i++) begin
            note = 7'(spot_notes[i]);
            step("map");
            check($sformatf("map.note%0d", spot_notes[i]), int'(increment), spot_exp[i]);
        end

        // note 69 from reset: 10 edges after latch
        async_reset("arst69");
        note = 7'd69;
        step("n69.latch");
        repeat (10) step("n69");
        check("n69.phase", int'(dut.phase), 147640);
        check("n69.saw", int'(saw), 2306);
        check("n69.tri", int'(triangle), 4612);
        check("n69.pulse", int'(pulse), 0);

        // note 60 from reset: 240 edges give two saw wraps and one full sub cycle
        async_reset("arst60");
        note = 7'd60;
        step("n60.latch");
        saw_drops = 0;
        sub_flips = 0;
        prev_saw  = int'(saw);
        prev_sub  = int'(sub);
        for (int i = 0; i < 240; i++) begin
            step("n60");
            if (int'(saw) < prev_saw) saw_drops++;
            if (int'(sub) != prev_sub) sub_flips++;
            prev_saw = int'(saw);
            prev_sub = int'(sub);
        end
        check("n60.saw_wraps", saw_drops, 2);
        check("n60.sub_flips", sub_flips, 2);
        check("n60.sub_end", int'(sub), 0);

        // note change mid-run: increment updates, phase continues
        repeat (37) step("n60b");
        prev_phase = int'(dut.phase);
        note = 7'd72;
        step("n72.latch");
        check("n72.inc", int'(increment), 17557);
        check("n72.phase_cont", int'(dut.phase), (prev_phase + 8778) % (1 << 20));
        step("n72.slope");
        check("n72.phase_slope", int'(dut.phase), (prev_phase + 8778 + 17557) % (1 << 20));

        // randomized notes and occasional async resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) note = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 120) == 0) async_reset("rnd.arst");
            step("rnd");
        end

        // high notes stress wraps every few samples
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) note = 7'($urandom_range(84, 127));
            step("hi");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/note_oscillator.md
# note_oscillator

Single-voice tone source for the audio synth. It converts a 7-bit MIDI note number into a 16-bit phase increment and advances one shared phase accumulator at the audio sample rate. From that phase it produces saw, triangle, pulse and sub-octave square waveforms in parallel. It sits between the note/voice control registers and the mixer/envelope stage, clocked by the 31.25 kHz sample clock (8 MHz / 256).

## Interface
- BITDEPTH, 14: width of each waveform output.
- BITFRACTION, 6: extra fractional phase bits; accumulator width ACCW = BITDEPTH + BITFRACTION (20 by default).
- sample_clock  in  1  sample-rate clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- midi_note  in  7  MIDI note number 0..127.
- increment  out  16  current phase increment (registered).
- saw  out  BITDEPTH  unsigned saw.
- triangle  out  BITDEPTH  unsigned triangle.
- pulse  out  BITDEPTH  unsigned 50% square.
- sub  out  BITDEPTH  unsigned square, one octave below.

## Operation
- Increment table: 12-entry ROM of 17-bit values for notes 84..95, value = round(f·2^20/31250), f = 440·2^((n−69)/12).
  - Values: 35115, 37203, 39415, 41759, 44242, 46873, 49660, 52613, 55741, 59056, 62567, 66288.
- Note mapping: octave o = midi_note/12, semitone s = midi_note mod 12.
  - o ≤ 7: raw = rom[s] >> (7−o), truncating.
  - o > 7: saturate.
  - raw > 65535: saturate.
  - Saturation gives increment = 65535, so notes 95..127 all produce 65535.
- Phase: ACCW-bit register; phase <= phase + increment each edge, modulo 2^ACCW. The carry out of this add is the wrap event.
- p = phase[ACCW−1 : BITFRACTION] (top BITDEPTH bits); m = p[MSB].
- saw = p.
- triangle = {p[BITDEPTH−2:0], 1'b0} XOR {BITDEPTH{m}}.
- pulse = m ? all-ones : 0.
- sub: toggle flop, inverted on every wrap event; sub = toggle ? all-ones : 0.
- All outputs are unsigned and derived only from registers; waveform outputs are combinational decodes of the phase and toggle registers.

## Timing
- Reset (rst=0, asynchronous) clears:
  - increment = 0, phase = 0, sub toggle = 0.
  - Therefore all waveform outputs = 0, except triangle = 0 (p = 0).
- Release is synchronous to sample_clock. The first edge after release latches increment; phase stays 0 on that edge because it adds the reset increment of 0.
- Latency:
  - midi_note change before edge k → increment valid after edge k.
  - The phase first uses the new increment at edge k+1.
  - Waveforms reflect it immediately after edge k+1.
- Note change mid-cycle: phase is continuous, with no reset or discontinuity in the accumulator; only the slope changes.
- Wrap: the phase wraps silently. The sub toggle flips on the same edge the wrap occurs.
- Reset asserted mid-operation: all state clears immediately, independent of sample_clock.

## Structure
- Shared synth package: the ROM constant array, sample-rate constant (31250), and the default BITDEPTH/BITFRACTION.
- Sub-module midi_note_to_accumulator (sample_clock, rst, midi_note → registered increment). It contains the divide-by-12, ROM, shifter and saturation.
- Top module holds one phase accumulator, the sub toggle and the four waveform decoders. The accumulator is not duplicated per waveform.

## Test plan
- Reset: hold rst=0 with midi_note=60 and toggle sample_clock → increment=0, every output 0. Release; one edge later → increment=8778, phase still 0.
- Mapping spot-checks: note 60 → 8778; 69 → 14764; 84 → 35115; 94 → 62567; 95 → 65535; 127 → 65535; 0 → 274.
- Note 69, defaults, 10 edges after the increment latches → phase=147640, saw=2306, triangle=4612, pulse=0.
- Note 60 run for 240 edges → saw wraps twice (periods of 119/120 samples). pulse is high for the upper half of each period. sub completes one full cycle of 2 saw periods.
- Change note 60 → 72 mid-run → increment=17557 one edge later; phase continues from its prior value with no jump.
- Assert rst between sample_clock edges mid-run → outputs go to 0 immediately; operation resumes from phase 0 after release.
